// File: rtl/carry_lookahead_adder_pkg.sv
// Shared constants and reference arithmetic for the carry-lookahead adder.
// Optional build macro: CARRY_LOOKAHEAD_ADDER_IN_REG_EN (see top module).
package cla_pkg;

    localparam int CLA_DEFAULT_WIDTH = 3;

    // Zero-extended unsigned sum of two operands of up to 32 bits
    function automatic logic [32:0] cla_ref_sum(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_if.sv
// Operand/result bundle for the carry-lookahead adder.
// Optional build macro: CARRY_LOOKAHEAD_ADDER_IN_REG_EN (no effect here).
interface carry_lookahead_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] add1;
    logic [WIDTH-1:0] add2;
    logic [WIDTH:0]   result;

    modport master (
        output add1,
        output add2,
        input  result
    );

    modport slave (
        input  add1,
        input  add2,
        output result
    );
endinterface

// File: rtl/carry_lookahead_adder_sum_cell.sv
// Per-bit generate/propagate/sum cell of the carry-lookahead adder.
// Optional build macro: CARRY_LOOKAHEAD_ADDER_IN_REG_EN (no effect here).
module cla_sum_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic g_o,
    output logic p_o,
    output logic s_o
);
    assign g_o = a_i & b_i;
    assign p_o = a_i ^ b_i;
    assign s_o = p_o ^ c_i;
endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered unsigned carry-lookahead adder with carry-out.
// Optional build macro: CARRY_LOOKAHEAD_ADDER_IN_REG_EN adds operand registers.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result
);
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;

`ifdef CARRY_LOOKAHEAD_ADDER_IN_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Capture operands; the adder works on the registered copies
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= i_add1;
            b_q <= i_add2;
        end
    end

    assign a_op = a_q;
    assign b_op = b_q;
`else
    assign a_op = i_add1;
    assign b_op = i_add2;
`endif

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;
    logic             term;
    logic [WIDTH:0]   result_d;
    logic [WIDTH:0]   result_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        cla_sum_cell u_cell (
            .a_i (a_op[i]),
            .b_i (b_op[i]),
            .c_i (c[i]),
            .g_o (g[i]),
            .p_o (p[i]),
            .s_o (s[i])
        );
    end

    // Flat lookahead: c[i+1] = OR_j ( g[j] & p[j+1] & ... & p[i] )
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    // Next result is carry-out above the sum bits
    always_comb begin
        result_d = {c[WIDTH], s};
    end

    // Output register, cleared immediately by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboard bench for carry_lookahead_adder at WIDTH 3, 16 and 1.
// Honours CARRY_LOOKAHEAD_ADDER_IN_REG_EN for the expected latency.
module tb_carry_lookahead_adder;

`ifdef CARRY_LOOKAHEAD_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    carry_lookahead_adder_if #(.WIDTH(3))  bus3  ();
    carry_lookahead_adder_if #(.WIDTH(16)) bus16 ();
    carry_lookahead_adder_if #(.WIDTH(1))  bus1  ();

    carry_lookahead_adder #(.WIDTH(3)) dut3 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_add1   (bus3.add1),
        .i_add2   (bus3.add2),
        .o_result (bus3.result)
    );

    carry_lookahead_adder #(.WIDTH(16)) dut16 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_add1   (bus16.add1),
        .i_add2   (bus16.add2),
        .o_result (bus16.result)
    );

    carry_lookahead_adder #(.WIDTH(1)) dut1 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_add1   (bus1.add1),
        .i_add2   (bus1.add2),
        .o_result (bus1.result)
    );

    typedef struct {
        int          due;
        logic [3:0]  e3;
        logic [16:0] e16;
        logic [1:0]  e1;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "/w3"},  17'(bus3.result),  17'd0);
        chk({name, "/w16"}, 17'(bus16.result), 17'd0);
        chk({name, "/w1"},  17'(bus1.result),  17'd0);
    endtask

    // Monitor: compare every due expectation just after the clock edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk({e.tag, "/late"}, 17'(e.due), 17'(cyc));
            end else begin
                chk({e.tag, "/w3"},  17'(bus3.result),  17'(e.e3));
                chk({e.tag, "/w16"}, bus16.result,      e.e16);
                chk({e.tag, "/w1"},  17'(bus1.result),  17'(e.e1));
            end
        end
    end

    function automatic exp_t mk(input int due, input logic [3:0] e3,
                                input string tag);
        exp_t e;
        e.due = due;
        e.e3  = e3;
        e.e16 = {1'b0, bus16.add1} + {1'b0, bus16.add2};
        e.e1  = {1'b0, bus1.add1} + {1'b0, bus1.add2};
        e.tag = tag;
        return e;
    endfunction

    // Drive one vector at the falling edge and queue its expectation
    task automatic drive(input string tag, input logic [2:0] a,
                         input logic [2:0] b, input logic [3:0] e3);
        @(negedge clk);
        bus3.add1  = a;
        bus3.add2  = b;
        bus16.add1 = 16'($urandom);
        bus16.add2 = 16'($urandom);
        bus1.add1  = 1'($urandom);
        bus1.add2  = 1'($urandom);
        sb.push_back(mk(cyc + LAT, e3, tag));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk({tag, "/drain"}, 17'(sb.size()), 17'd0);
        sb.delete();
    endtask

    // Reset is released at a falling edge; a cleared input stage shows 0 first
    task automatic release_reset(input logic [3:0] e3, input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        if (LAT == 2) begin
            exp_t z;
            z     = mk(cyc + 1, 4'd0, {tag, "/pre"});
            z.e16 = '0;
            z.e1  = '0;
            sb.push_back(z);
        end
        sb.push_back(mk(cyc + LAT, e3, tag));
    endtask

    initial begin
        bus3.add1  = 3'd7;
        bus3.add2  = 3'd7;
        bus16.add1 = 16'hffff;
        bus16.add2 = 16'hffff;
        bus1.add1  = 1'b1;
        bus1.add2  = 1'b1;

        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("rst_hold");
        end

        release_reset(4'b1110, "rst_release");
        drain("rst_release");

        drive("v0p1", 3'b000, 3'b001, 4'b0001);
        drive("v2p2", 3'b010, 3'b010, 4'b0100);
        drive("v5p6", 3'b101, 3'b110, 4'b1011);
        drive("v7p7", 3'b111, 3'b111, 4'b1110);
        drive("b2b_a", 3'b011, 3'b001, 4'b0100);
        drive("b2b_b", 3'b011, 3'b001, 4'b0100);
        drive("b2b_c", 3'b100, 3'b100, 4'b1000);
        drive("b2b_d", 3'b001, 3'b110, 4'b0111);
        drive("b2b_e", 3'b000, 3'b000, 4'b0000);
        drain("directed");

        drive("pre_mid", 3'b101, 3'b110, 4'b1011);
        drain("pre_mid");
        chk("mid_val", 17'(bus3.result), 17'b1011);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        chk_all_zero("rst_mid_hold");
        release_reset(4'b1011, "rst_mid_release");
        drain("rst_mid_release");

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                logic [3:0] s;
                s = 4'(a) + 4'(b);
                drive($sformatf("sweep_%0d_%0d", a, b), 3'(a), 3'(b), s);
            end
        end
        drain("sweep");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
